uart_port_arbiter: RTL and testbench

Shares the byte-level CPU-side ports of the UART controller between `NUM_REQ` requesters, e.g. the core's I/O unit and the debug/boot loader. There are two independent channels: TX feeds the controller's `uart_in_*` side (bytes to transmit), and RX drains its `uart_out_*` side (received bytes). Each channel runs its own round-robin arbiter with an optional per-requester lock, so a multi-byte packet goes through uninterleaved.

---
 rtl/uart_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_arbiter.sv
// Shares the UART controller's byte ports between NUM_REQ requesters. TX and RX each
// get an independent round-robin arbiter with an optional per-requester packet lock.

module uart_rr_channel #(
    parameter int NUM_REQ = 2,
    parameter int OWNER_W = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_lock,
    input  logic               done,
    output logic               grant,
    output logic [OWNER_W-1:0] win,
    output logic [OWNER_W-1:0] owner,
    output logic               busy,
    output logic [NUM_REQ-1:0] ready
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state, state_nxt;
    logic               locked, locked_nxt;
    logic [OWNER_W-1:0] last;
    logic [OWNER_W-1:0] rr_win;
    logic               rr_found;

    // First valid requester after the last grantee, wrapping modulo NUM_REQ.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req_valid[(int'(last) + k) % NUM_REQ]) begin
                rr_found = 1'b1;
                rr_win   = OWNER_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        locked_nxt = locked;
        grant      = 1'b0;
        win        = rr_win;
        case (state)
            IDLE: begin
                if (locked && req_lock[owner]) begin
                    if (req_valid[owner]) begin
                        grant = 1'b1;
                        win   = owner;
                    end
                end else begin
                    // Lock released: fall through to a normal arbitration this cycle.
                    locked_nxt = 1'b0;
                    grant      = rr_found;
                end
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (done) begin
                    state_nxt  = IDLE;
                    locked_nxt = req_lock[owner];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            locked <= 1'b0;
            last   <= OWNER_W'(NUM_REQ - 1);
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            locked <= locked_nxt;
            if (grant) begin
                last  <= win;
                owner <= win;
            end
        end
    end

    assign busy = (state == ISSUE);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign ready[i] = done && busy && (owner == OWNER_W'(i));
    end
endmodule

module uart_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   tx_valid,
    input  logic [NUM_REQ*8-1:0] tx_data,
    input  logic [NUM_REQ-1:0]   tx_lock,
    output logic [NUM_REQ-1:0]   tx_ready,
    input  logic [NUM_REQ-1:0]   rx_valid,
    input  logic [NUM_REQ-1:0]   rx_lock,
    output logic [NUM_REQ-1:0]   rx_ready,
    output logic [7:0]           rx_data,
    output logic                 uart_in_valid,
    output logic [7:0]           uart_in_data,
    input  logic                 uart_in_ready,
    output logic                 uart_out_valid,
    input  logic [7:0]           uart_out_data,
    input  logic                 uart_out_ready,
    output logic [OWNER_W-1:0]   tx_owner,
    output logic [OWNER_W-1:0]   rx_owner,
    output logic                 tx_busy,
    output logic                 rx_busy
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || OWNER_W < 1) begin : g_bad_param
        $error("uart_port_arbiter: NUM_REQ must be 2..8 and OWNER_W >= 1");
    end

    logic [NUM_REQ-1:0][7:0] tx_bytes;
    logic                    tx_grant;
    logic [OWNER_W-1:0]      tx_win;
    logic                    rx_grant_unused;
    logic [OWNER_W-1:0]      rx_win_unused;

    assign tx_bytes = tx_data;

    uart_rr_channel #(.NUM_REQ(NUM_REQ), .OWNER_W(OWNER_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .req_valid (tx_valid),
        .req_lock  (tx_lock),
        .done      (uart_in_ready),
        .grant     (tx_grant),
        .win       (tx_win),
        .owner     (tx_owner),
        .busy      (tx_busy),
        .ready     (tx_ready)
    );

    uart_rr_channel #(.NUM_REQ(NUM_REQ), .OWNER_W(OWNER_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .req_valid (rx_valid),
        .req_lock  (rx_lock),
        .done      (uart_out_ready),
        .grant     (rx_grant_unused),
        .win       (rx_win_unused),
        .owner     (rx_owner),
        .busy      (rx_busy),
        .ready     (rx_ready)
    );

    // Controller-side valids are the ISSUE state flops themselves, so they drop the
    // cycle after the accept pulse and can never be double-accepted.
    assign uart_in_valid  = tx_busy;
    assign uart_out_valid = rx_busy;
    assign rx_data        = uart_out_data;

    // Data is captured at grant only; the requester may change tx_data afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        uart_in_data <= '0;
        else if (tx_grant) uart_in_data <= tx_bytes[tx_win];
    end
endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: transaction-level arbitration model checked every
// cycle, plus directed scenarios with hand-computed byte orders and timing.

module tb_uart_port_arbiter;
    localparam int N  = 3;
    localparam int OW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      tx_valid = '0, tx_lock = '0, rx_valid = '0, rx_lock = '0;
    logic [N-1:0][7:0] txb = '0;
    logic [N*8-1:0]    tx_data;
    logic [N-1:0]      tx_ready, rx_ready;
    logic [7:0]        rx_data, uart_in_data;
    logic              uart_in_valid, uart_out_valid;
    logic              uart_in_ready = 1'b0, uart_out_ready = 1'b0;
    logic [7:0]        uart_out_data = '0;
    logic [OW-1:0]     tx_owner, rx_owner;
    logic              tx_busy, rx_busy;

    logic auto_tx = 1'b0, auto_rx = 1'b0, man_in_rdy = 1'b0, man_out_rdy = 1'b0;
    logic tx_v_prev = 1'b0, rx_v_prev = 1'b0;
    int   cyc = 0;
    int   n_checks = 0, n_errs = 0;
    int   txq[$], txc[$], rxq[$], rxo[$], rxc[$];

    assign tx_data = txb;

    always #5 clk = ~clk;

    uart_port_arbiter #(.NUM_REQ(N), .OWNER_W(OW)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_lock(tx_lock), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_lock(rx_lock), .rx_ready(rx_ready), .rx_data(rx_data),
        .uart_in_valid(uart_in_valid), .uart_in_data(uart_in_data), .uart_in_ready(uart_in_ready),
        .uart_out_valid(uart_out_valid), .uart_out_data(uart_out_data), .uart_out_ready(uart_out_ready),
        .tx_owner(tx_owner), .rx_owner(rx_owner), .tx_busy(tx_busy), .rx_busy(rx_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic busy;
        int   owner;
        int   last;
        logic locked;
    } ch_t;

    localparam ch_t CH_RST = '{busy: 1'b0, owner: 0, last: N - 1, locked: 1'b0};

    ch_t        mt = CH_RST, mr = CH_RST;
    logic [7:0] mt_data = '0;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic ch_t ch_step(input ch_t s, input logic [N-1:0] v,
                                    input logic [N-1:0] lk, input logic done);
        ch_t n = s;
        int  w;
        if (s.busy) begin
            if (done) begin
                n.busy   = 1'b0;
                n.locked = lk[s.owner];
            end
        end else if (s.locked && lk[s.owner]) begin
            if (v[s.owner]) n.busy = 1'b1;
        end else begin
            n.locked = 1'b0;
            w = rr_pick(s.last, v);
            if (w >= 0) begin
                n.busy  = 1'b1;
                n.owner = w;
                n.last  = w;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mt      <= CH_RST;
            mr      <= CH_RST;
            mt_data <= '0;
        end else begin
            mt <= ch_step(mt, tx_valid, tx_lock, uart_in_ready);
            mr <= ch_step(mr, rx_valid, rx_lock, uart_out_ready);
            if (!mt.busy && ch_step(mt, tx_valid, tx_lock, uart_in_ready).busy)
                mt_data <= txb[ch_step(mt, tx_valid, tx_lock, uart_in_ready).owner];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Controller stand-in: accept in the second cycle of each ISSUE.
    always @(posedge clk) begin
        #2;
        uart_in_ready  = auto_tx ? (uart_in_valid && tx_v_prev) : man_in_rdy;
        tx_v_prev      = uart_in_valid;
        uart_out_ready = auto_rx ? (uart_out_valid && rx_v_prev) : man_out_rdy;
        rx_v_prev      = uart_out_valid;
    end

    // Per-cycle compare against the model, and transfer logging.
    always @(negedge clk) begin
        logic [N-1:0] etr, err;
        etr = (mt.busy && uart_in_ready)  ? (N'(1) << mt.owner) : '0;
        err = (mr.busy && uart_out_ready) ? (N'(1) << mr.owner) : '0;
        chk("uart_in_valid",  uart_in_valid,  mt.busy);
        chk("tx_busy",        tx_busy,        mt.busy);
        chk("tx_owner",       tx_owner,       32'(mt.owner));
        chk("uart_in_data",   uart_in_data,   mt_data);
        chk("tx_ready",       tx_ready,       etr);
        chk("uart_out_valid", uart_out_valid, mr.busy);
        chk("rx_busy",        rx_busy,        mr.busy);
        chk("rx_owner",       rx_owner,       32'(mr.owner));
        chk("rx_ready",       rx_ready,       err);
        if (err != '0) chk("rx_data", rx_data, uart_out_data);
        if (uart_in_valid && uart_in_ready) begin
            txq.push_back(int'(uart_in_data));
            txc.push_back(cyc);
        end
        if (rx_ready != '0) begin
            rxq.push_back(int'(rx_data));
            rxo.push_back($clog2(int'(rx_ready)));
            rxc.push_back(cyc);
        end
    end

    task automatic wait_tx(input int n);
        int t = 0;
        while (txq.size() < n && t < 60) begin
            @(negedge clk); #1;
            t++;
        end
        chk("tx_wait_timeout", txq.size() >= n, 1'b1);
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rxq.size() < n && t < 60) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rx_wait_timeout", rxq.size() >= n, 1'b1);
    endtask

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_in_valid", uart_in_valid, 0);
        chk("rst_in_data",  uart_in_data,  0);
        chk("rst_out_valid", uart_out_valid, 0);
        chk("rst_tx_owner", tx_owner, 0);
        chk("rst_rx_owner", rx_owner, 0);
        repeat (2) edge1();
        reset = 1'b1;
        edge1();

        // Round-robin: all three requesters held high
        auto_tx = 1'b1;
        txb = '{8'h32, 8'h21, 8'h10};
        tx_valid = 3'b111;
        wait_tx(4);
        edge1();
        tx_valid = '0;
        if (txq.size() >= 4) begin
            chk("rr_byte0", txq[0], 32'h10);
            chk("rr_byte1", txq[1], 32'h21);
            chk("rr_byte2", txq[2], 32'h32);
            chk("rr_byte3", txq[3], 32'h10);
            chk("rr_period01", txc[1] - txc[0], 3);
            chk("rr_period23", txc[3] - txc[2], 3);
        end
        repeat (2) edge1();

        // Lock: requester 1 sends A0,A1,A2 while requester 0 waits
        txq.delete(); txc.delete();
        txb = '{8'h00, 8'hA0, 8'h55};
        tx_lock = 3'b010;
        tx_valid = 3'b011;
        wait_tx(1);
        edge1(); txb[1] = 8'hA1;
        wait_tx(2);
        edge1(); txb[1] = 8'hA2;
        edge1(); tx_lock = '0;
        wait_tx(3);
        edge1(); tx_valid = 3'b001;
        wait_tx(4);
        edge1(); tx_valid = '0;
        if (txq.size() >= 4) begin
            chk("lock_byte0", txq[0], 32'hA0);
            chk("lock_byte1", txq[1], 32'hA1);
            chk("lock_byte2", txq[2], 32'hA2);
            chk("lock_byte3", txq[3], 32'h55);
            chk("lock_b2b_period", txc[1] - txc[0], 3);
        end
        repeat (2) edge1();

        // Lock idle hold: owner keeps lock, drops valid; other requester waits
        txq.delete(); txc.delete();
        txb = '{8'h00, 8'hB0, 8'h66};
        tx_lock = 3'b010;
        tx_valid = 3'b010;
        wait_tx(1);
        edge1(); tx_valid = 3'b001;
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk("hold_no_grant", uart_in_valid, 0);
        end
        tx_lock = '0;
        edge1();
        chk("hold_release_valid", uart_in_valid, 1);
        chk("hold_release_owner", tx_owner, 0);
        wait_tx(2);
        edge1(); tx_valid = '0;
        if (txq.size() >= 2) chk("hold_byte", txq[1], 32'h66);
        repeat (2) edge1();

        // Reset mid-ISSUE, then requester 0 wins first
        txq.delete(); txc.delete();
        txb = '{8'h00, 8'h72, 8'h71};
        tx_valid = 3'b011;
        auto_tx = 1'b0;
        rx_valid = 3'b001;
        edge1();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_in_valid", uart_in_valid, 0);
        chk("async_rst_in_data",  uart_in_data, 0);
        chk("async_rst_tx_busy",  tx_busy, 0);
        chk("async_rst_out_valid", uart_out_valid, 0);
        chk("async_rst_rx_busy",  rx_busy, 0);
        chk("async_rst_tx_owner", tx_owner, 0);
        edge1();
        rx_valid = '0;
        reset = 1'b1;
        auto_tx = 1'b1;
        wait_tx(2);
        edge1(); tx_valid = '0;
        if (txq.size() >= 2) begin
            chk("post_rst_first", txq[0], 32'h71);
            chk("post_rst_second", txq[1], 32'h72);
        end
        repeat (2) edge1();

        // RX stall with empty controller buffer
        rx_valid = 3'b010;
        repeat (4) edge1();
        chk("stall_out_valid", uart_out_valid, 1);
        chk("stall_rx_busy",   rx_busy, 1);
        chk("stall_rx_owner",  rx_owner, 1);
        uart_out_data = 8'h5C;
        man_out_rdy = 1'b1;
        #2;
        chk("stall_rx_ready", rx_ready, 3'b010);
        chk("stall_rx_data",  rx_data, 8'h5C);
        edge1();
        man_out_rdy = 1'b0;
        rx_valid = '0;
        #2;
        chk("stall_ready_gone", rx_ready, 0);
        chk("stall_valid_gone", uart_out_valid, 0);
        repeat (2) edge1();

        // Concurrent TX (req 0) and RX (req 1)
        txq.delete(); txc.delete(); rxq.delete(); rxo.delete(); rxc.delete();
        auto_rx = 1'b1;
        uart_out_data = 8'h3C;
        txb[0] = 8'h5A;
        c0 = cyc;
        tx_valid = 3'b001;
        rx_valid = 3'b010;
        wait_tx(1);
        wait_rx(1);
        edge1();
        tx_valid = '0;
        rx_valid = '0;
        if (txq.size() >= 1 && rxq.size() >= 1) begin
            chk("conc_tx_byte",  txq[0], 32'h5A);
            chk("conc_tx_cycle", txc[0] - c0, 2);
            chk("conc_rx_byte",  rxq[0], 32'h3C);
            chk("conc_rx_owner", rxo[0], 1);
            chk("conc_rx_cycle", rxc[0] - c0, 2);
        end
        repeat (3) edge1();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
